// File: rtl/wb_merge.sv
// -----------------------------------------------------------------------------
// wb_merge
//   Writeback merge stage behind the execute units (port 0 = ALU, 1 = LSU,
//   2 = MUL/DIV). The execute units cannot be stalled once a result is
//   produced, so every result is captured into a small per-port FIFO. The FIFO
//   heads are arbitrated round-robin onto a single valid/ready result bus that
//   feeds the scoreboard/commit stage.
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous, active-low reset
//   flush_ex_i   drop every buffered and same-cycle incoming result
//   wb_vld_i     per-port result valid (no backpressure)
//   wb_id_i      per-port trans_id, port i at [i*ADDR_BITS +: ADDR_BITS]
//   wb_data_i    per-port result, port i at [i*32 +: 32]
//   fifo_full_o  per-port FIFO holds DEPTH entries (issue stalls that unit)
//   wb_vld_o     merged result valid
//   wb_id_o      merged trans_id
//   wb_data_o    merged result
//   wb_src_o     source port of the presented result
//   wb_rdy_i     consumer accepts the presented result
//   overflow_o   sticky: a result arrived at a full FIFO and was dropped
//
// Handshake (valid/ready): a result transfers on every rising edge where
//   wb_vld_o && wb_rdy_i. Once wb_vld_o is high it stays high, and wb_id_o,
//   wb_data_o and wb_src_o stay stable, until that transfer edge. wb_vld_o
//   never depends combinationally on wb_rdy_i.
// -----------------------------------------------------------------------------
module wb_merge #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_BITS = 3,
   parameter int DEPTH     = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_ex_i,
   input  logic [NUM_PORTS-1:0]           wb_vld_i,
   input  logic [NUM_PORTS*ADDR_BITS-1:0] wb_id_i,
   input  logic [NUM_PORTS*32-1:0]        wb_data_i,
   output logic [NUM_PORTS-1:0]           fifo_full_o,
   output logic                           wb_vld_o,
   output logic [ADDR_BITS-1:0]           wb_id_o,
   output logic [31:0]                    wb_data_o,
   output logic [$clog2(NUM_PORTS)-1:0]   wb_src_o,
   input  logic                           wb_rdy_i,
   output logic                           overflow_o
);

   localparam int SW  = $clog2(NUM_PORTS);
   localparam int SW1 = SW + 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int EW  = ADDR_BITS + 32;

   localparam logic [PW-1:0]  DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0]  LAST_P   = PW'(DEPTH - 1);
   localparam logic [PW-1:0]  ONE_P    = PW'(1);
   localparam logic [SW1-1:0] NP_S     = SW1'(NUM_PORTS);
   localparam logic [SW-1:0]  LAST_SRC = SW'(NUM_PORTS - 1);
   localparam logic [SW-1:0]  ONE_S    = SW'(1);

   // Grant lock: OPEN lets the round-robin scan pick a port each cycle,
   // LOCKED pins the grant to lock_idx_q while the consumer is stalling.
   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t                  state_q, state_d;
   logic [SW-1:0]                lock_idx_q, lock_idx_d;
   logic [SW-1:0]                rr_ptr_q;
   logic                         ovf_q;

   logic [NUM_PORTS-1:0]         empty;
   logic [NUM_PORTS-1:0]         full;
   logic [NUM_PORTS-1:0]         pop;
   logic [NUM_PORTS-1:0]         push_ok;
   logic [NUM_PORTS-1:0]         push_drop;
   logic [NUM_PORTS-1:0][EW-1:0] head;

   logic                         scan_vld;
   logic [SW-1:0]                scan_idx;
   logic [SW1-1:0]               cand;
   logic                         gnt_vld;
   logic [SW-1:0]                gnt_idx;
   logic                         handshake;

   // ---------------------------------------------------------------------------
   // Per-port FIFOs
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
      logic [EW-1:0] mem [DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [PW-1:0] count;
      logic [AW-1:0] wr_idx;
      logic [AW-1:0] rd_idx;

      // Pointers only ever hold 0..DEPTH-1; the modulo keeps the index in
      // range even if that invariant were ever broken.
      assign wr_idx   = AW'(wr_ptr % DEPTH_P);
      assign rd_idx   = AW'(rd_ptr % DEPTH_P);

      assign empty[g] = (count == '0);
      assign full[g]  = (count == DEPTH_P);
      assign head[g]  = mem[rd_idx];

      assign pop[g]   = handshake && (gnt_idx == SW'(g));

      // A full FIFO still takes a result when its head leaves on the same
      // edge. Flush discards incoming results without flagging overflow.
      assign push_ok[g]   = wb_vld_i[g] && !flush_ex_i && (!full[g] || pop[g]);
      assign push_drop[g] = wb_vld_i[g] && !flush_ex_i && full[g] && !pop[g];

      always_ff @(posedge clk_i) begin
         if (!rst_ni || flush_ex_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok[g]) begin
               wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + ONE_P;
            end
            if (pop[g]) begin
               rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + ONE_P;
            end
            case ({push_ok[g], pop[g]})
               2'b10:   count <= count + ONE_P;
               2'b01:   count <= count - ONE_P;
               default: count <= count;
            endcase
         end
      end

      // Storage needs no reset: an entry is only read while count says it
      // holds valid data.
      always_ff @(posedge clk_i) begin
         if (push_ok[g]) begin
            mem[wr_idx] <= {wb_id_i[g*ADDR_BITS +: ADDR_BITS], wb_data_i[g*32 +: 32]};
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin scan: first non-empty FIFO at or above rr_ptr, with wrap.
   // Walking the offsets from highest to lowest lets the lowest offset
   // overwrite the result, so the closest port to rr_ptr wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      scan_vld = 1'b0;
      scan_idx = '0;
      cand     = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + SW1'(k);
         if (cand >= NP_S) begin
            cand = cand - NP_S;
         end
         if (!empty[cand[SW-1:0]]) begin
            scan_vld = 1'b1;
            scan_idx = cand[SW-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Grant lock FSM: next state and grant selection
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      gnt_vld    = scan_vld;
      gnt_idx    = scan_idx;

      // A locked port cannot have drained (only a handshake pops it), so the
      // grant stays valid for as long as the lock holds.
      if (state_q == ST_LOCKED) begin
         gnt_vld = 1'b1;
         gnt_idx = lock_idx_q;
      end

      handshake = gnt_vld && wb_rdy_i;

      if (flush_ex_i) begin
         state_d = ST_OPEN;
      end else if (gnt_vld && !wb_rdy_i) begin
         state_d    = ST_LOCKED;
         lock_idx_d = gnt_idx;
      end else begin
         state_d = ST_OPEN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_OPEN;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin pointer and sticky overflow
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
      end else if (handshake && !flush_ex_i) begin
         rr_ptr_q <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + ONE_S;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
      end else if (|push_drop) begin
         ovf_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only, zero when nothing is granted
   // ---------------------------------------------------------------------------
   assign fifo_full_o = full;
   assign overflow_o  = ovf_q;
   assign wb_vld_o    = gnt_vld;
   assign wb_src_o    = gnt_vld ? gnt_idx : '0;
   assign wb_id_o     = gnt_vld ? head[gnt_idx][EW-1:32] : '0;
   assign wb_data_o   = gnt_vld ? head[gnt_idx][31:0] : '0;

endmodule

// File: tb/tb_wb_merge.sv
// -----------------------------------------------------------------------------
// tb_wb_merge
//   Bench for wb_merge. A queue-per-port reference model tracks what each
//   FIFO should hold, which port should be presented and the sticky overflow
//   flag; every cycle the observed outputs are compared against it, and the
//   directed scenarios add fixed expected values on top.
//
//   Observation vector layout (OW bits):
//     [41] overflow_o  [40:38] fifo_full_o  [37] wb_vld_o
//     [36:35] wb_src_o [34:32] wb_id_o      [31:0] wb_data_o
// -----------------------------------------------------------------------------
module tb_wb_merge;

   localparam int NP    = 3;
   localparam int AB    = 3;
   localparam int DEPTH = 4;
   localparam int SW    = 2;
   localparam int EW    = AB + 32;
   localparam int OW    = 1 + NP + 1 + SW + EW;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               flush_ex_i;
   logic [NP-1:0]      wb_vld_i;
   logic [NP*AB-1:0]   wb_id_i;
   logic [NP*32-1:0]   wb_data_i;
   logic [NP-1:0]      fifo_full_o;
   logic               wb_vld_o;
   logic [AB-1:0]      wb_id_o;
   logic [31:0]        wb_data_o;
   logic [SW-1:0]      wb_src_o;
   logic               wb_rdy_i;
   logic               overflow_o;

   always #5 clk_i = ~clk_i;

   wb_merge #(
      .NUM_PORTS (NP),
      .ADDR_BITS (AB),
      .DEPTH     (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_ex_i  (flush_ex_i),
      .wb_vld_i    (wb_vld_i),
      .wb_id_i     (wb_id_i),
      .wb_data_i   (wb_data_i),
      .fifo_full_o (fifo_full_o),
      .wb_vld_o    (wb_vld_o),
      .wb_id_o     (wb_id_o),
      .wb_data_o   (wb_data_o),
      .wb_src_o    (wb_src_o),
      .wb_rdy_i    (wb_rdy_i),
      .overflow_o  (overflow_o)
   );

   // ---------------------------------------------------------------------------
   // Reference model / scoreboard
   // ---------------------------------------------------------------------------
   logic [EW-1:0] exp_q [NP][$];
   int            m_rr;
   int            m_lock;
   logic          m_ovf;

   int            n_checks;
   int            n_errors;

   // Port that should be presented now, or -1 when nothing is buffered.
   function automatic int model_pick();
      if (m_lock >= 0) return m_lock;
      for (int k = 0; k < NP; k++) begin
         if (exp_q[(m_rr + k) % NP].size() > 0) return (m_rr + k) % NP;
      end
      return -1;
   endfunction

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic idle(input logic r);
      wb_vld_i   = '0;
      wb_id_i    = '0;
      wb_data_i  = '0;
      wb_rdy_i   = r;
      flush_ex_i = 1'b0;
   endtask

   task automatic push_one(input int p, input int id, input logic [31:0] d, input logic r);
      idle(r);
      wb_vld_i[p]           = 1'b1;
      wb_id_i[p*AB +: AB]   = AB'(id);
      wb_data_i[p*32 +: 32] = d;
   endtask

   // One clock: sample outputs at the falling edge, form the model's
   // expectation for that same moment, then advance the model across the
   // rising edge with the inputs that were applied.
   task automatic tick(output logic [OW-1:0] obs, output logic [OW-1:0] exp);
      int            src;
      logic [NP-1:0] full_e;
      logic [EW-1:0] head;
      @(negedge clk_i);
      src  = model_pick();
      head = '0;
      if (src >= 0) head = exp_q[src][0];
      for (int p = 0; p < NP; p++) full_e[p] = (exp_q[p].size() == DEPTH);
      exp = {m_ovf, full_e, (src >= 0), (src >= 0) ? SW'(src) : SW'(0), head};
      obs = {overflow_o, fifo_full_o, wb_vld_o, wb_src_o, wb_id_o, wb_data_o};
      @(posedge clk_i);
      if (!rst_ni) begin
         for (int p = 0; p < NP; p++) exp_q[p].delete();
         m_rr   = 0;
         m_lock = -1;
         m_ovf  = 1'b0;
      end else if (flush_ex_i) begin
         for (int p = 0; p < NP; p++) exp_q[p].delete();
         m_lock = -1;
      end else begin
         if (src >= 0 && wb_rdy_i) begin
            void'(exp_q[src].pop_front());
            m_rr = (src + 1) % NP;
         end
         for (int p = 0; p < NP; p++) begin
            if (wb_vld_i[p]) begin
               if (exp_q[p].size() < DEPTH)
                  exp_q[p].push_back({wb_id_i[p*AB +: AB], wb_data_i[p*32 +: 32]});
               else
                  m_ovf = 1'b1;
            end
         end
         m_lock = (src >= 0 && !wb_rdy_i) ? src : -1;
      end
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [OW-1:0] o, e;
      rst_ni = 1'b0;
      idle(1'b0);
      tick(o, e);
      tick(o, e);
      n_checks++;
      if (o !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs got=%h expected=%h", o, {OW{1'b0}});
      end
      rst_ni = 1'b1;
   endtask

   task automatic test_single();
      logic [OW-1:0] o, e;
      push_one(2, 5, 32'hDEADBEEF, 1'b1);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL single_before got=%h expected=%h", o, e); end
      idle(1'b1);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL single_model got=%h expected=%h", o, e); end
      n_checks++;
      if (o[37:0] !== {1'b1, 2'd2, 3'd5, 32'hDEADBEEF}) begin
         n_errors++;
         $display("FAIL single_present got=%h expected=%h", o[37:0], {1'b1, 2'd2, 3'd5, 32'hDEADBEEF});
      end
      tick(o, e);
      n_checks++;
      if (o[37] !== 1'b0 || o !== e) begin
         n_errors++;
         $display("FAIL single_popped got=%h expected=%h", o, e);
      end
   endtask

   task automatic test_round_robin();
      logic [OW-1:0] o, e;
      logic [5:0]    srcs;
      logic [8:0]    ids;
      srcs = '0;
      ids  = '0;
      wb_vld_i   = 3'b111;
      wb_id_i    = {3'd3, 3'd2, 3'd1};
      wb_data_i  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      wb_rdy_i   = 1'b1;
      flush_ex_i = 1'b0;
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL rr_push got=%h expected=%h", o, e); end
      idle(1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL rr_cycle%0d got=%h expected=%h", i, o, e); end
         if (i < 3) begin
            srcs = {srcs[3:0], o[36:35]};
            ids  = {ids[5:0], o[34:32]};
         end
      end
      n_checks++;
      if (srcs !== {2'd0, 2'd1, 2'd2} || ids !== {3'd1, 3'd2, 3'd3}) begin
         n_errors++;
         $display("FAIL rr_order got src=%h id=%h expected src=%h id=%h", srcs, ids, {2'd0, 2'd1, 2'd2}, {3'd1, 3'd2, 3'd3});
      end
   endtask

   task automatic test_stall_lock();
      logic [OW-1:0] o, e;
      logic [14:0]   stall;
      logic [4:0]    after;
      stall = '0;
      push_one(1, 4, 32'h0000_0044, 1'b0);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL lock_push got=%h expected=%h", o, e); end
      for (int i = 0; i < 3; i++) begin
         if (i == 0) push_one(0, 6, 32'h0000_0066, 1'b0);
         else        idle(i == 2);
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL lock_stall%0d got=%h expected=%h", i, o, e); end
         stall = {stall[9:0], o[36:32]};
      end
      idle(1'b1);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL lock_after got=%h expected=%h", o, e); end
      after = o[36:32];
      n_checks++;
      if (stall !== {3{2'd1, 3'd4}} || after !== {2'd0, 3'd6}) begin
         n_errors++;
         $display("FAIL lock_hold got stall=%h after=%h expected stall=%h after=%h", stall, after, {3{2'd1, 3'd4}}, {2'd0, 3'd6});
      end
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL lock_drain got=%h expected=%h", o, e); end
   endtask

   task automatic test_overflow();
      logic [OW-1:0] o, e;
      logic [11:0]   ids;
      ids = '0;
      for (int i = 0; i < 4; i++) begin
         push_one(2, i, 32'hA000_0000 + 32'(i), 1'b0);
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL ovf_fill%0d got=%h expected=%h", i, o, e); end
      end
      push_one(2, 7, 32'hA000_0007, 1'b0);
      tick(o, e);
      n_checks++;
      if (o !== e || o[40] !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_full got=%h expected=%h", o, e);
      end
      idle(1'b0);
      tick(o, e);
      n_checks++;
      if (o !== e || o[41] !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_flag got=%h expected=%h", o, e);
      end
      idle(1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL ovf_drain%0d got=%h expected=%h", i, o, e); end
         ids = {ids[8:0], o[34:32]};
      end
      n_checks++;
      if (ids !== {3'd0, 3'd1, 3'd2, 3'd3}) begin
         n_errors++;
         $display("FAIL ovf_order got=%h expected=%h", ids, {3'd0, 3'd1, 3'd2, 3'd3});
      end
      tick(o, e);
      n_checks++;
      if (o !== e || o[41:37] !== 5'b10000) begin
         n_errors++;
         $display("FAIL ovf_sticky got=%h expected=%h", o, e);
      end
   endtask

   task automatic test_mid_reset();
      logic [OW-1:0] o, e;
      wb_vld_i   = 3'b111;
      wb_id_i    = {3'd6, 3'd5, 3'd4};
      wb_data_i  = {32'hC3, 32'hC2, 32'hC1};
      wb_rdy_i   = 1'b0;
      flush_ex_i = 1'b0;
      tick(o, e);
      idle(1'b0);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL midrst_before got=%h expected=%h", o, e); end
      rst_ni = 1'b0;
      tick(o, e);
      rst_ni = 1'b1;
      tick(o, e);
      n_checks++;
      if (o !== '0 || o !== e) begin
         n_errors++;
         $display("FAIL midrst_cleared got=%h expected=%h", o, {OW{1'b0}});
      end
   endtask

   task automatic test_full_pop_push();
      logic [OW-1:0] o, e;
      logic [14:0]   ids;
      ids = '0;
      for (int i = 0; i < 4; i++) begin
         push_one(2, i, 32'hB000_0000 + 32'(i), 1'b0);
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL fpp_fill%0d got=%h expected=%h", i, o, e); end
      end
      push_one(2, 7, 32'hB000_0007, 1'b1);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL fpp_swap got=%h expected=%h", o, e); end
      ids = {ids[11:0], o[34:32]};
      idle(1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL fpp_drain%0d got=%h expected=%h", i, o, e); end
         ids = {ids[11:0], o[34:32]};
      end
      n_checks++;
      if (ids !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd7}) begin
         n_errors++;
         $display("FAIL fpp_order got=%h expected=%h", ids, {3'd0, 3'd1, 3'd2, 3'd3, 3'd7});
      end
      tick(o, e);
      n_checks++;
      if (o[41] !== 1'b0 || o !== e) begin
         n_errors++;
         $display("FAIL fpp_no_overflow got=%h expected=%h", o, e);
      end
   endtask

   task automatic test_flush();
      logic [OW-1:0] o, e;
      for (int r = 0; r < 2; r++) begin
         wb_vld_i   = 3'b111;
         wb_id_i    = {AB'(r + 4), AB'(r + 2), AB'(r)};
         wb_data_i  = {32'(r) + 32'hF200, 32'(r) + 32'hF100, 32'(r) + 32'hF000};
         wb_rdy_i   = 1'b0;
         flush_ex_i = 1'b0;
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL flush_fill%0d got=%h expected=%h", r, o, e); end
      end
      push_one(0, 7, 32'hF0F0_0007, 1'b0);
      flush_ex_i = 1'b1;
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL flush_edge got=%h expected=%h", o, e); end
      idle(1'b0);
      tick(o, e);
      n_checks++;
      if (o[41:37] !== 5'b00000 || o !== e) begin
         n_errors++;
         $display("FAIL flush_empty got=%h expected=%h", o, e);
      end
      push_one(1, 2, 32'h0000_0222, 1'b1);
      tick(o, e);
      idle(1'b1);
      tick(o, e);
      n_checks++;
      if (o[37:32] !== {1'b1, 2'd1, 3'd2} || o !== e) begin
         n_errors++;
         $display("FAIL flush_after got=%h expected=%h", o, e);
      end
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL flush_drain got=%h expected=%h", o, e); end
   endtask

   task automatic test_random();
      logic [OW-1:0] o, e;
      logic [31:0]   tmp;
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < NP; p++) begin
            wb_vld_i[p]           = ($urandom_range(0, 9) < 4);
            tmp                   = $urandom;
            wb_id_i[p*AB +: AB]   = tmp[AB-1:0];
            wb_data_i[p*32 +: 32] = $urandom;
         end
         wb_rdy_i   = ($urandom_range(0, 3) != 0);
         flush_ex_i = ($urandom_range(0, 39) == 0);
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL random_c%0d got=%h expected=%h", i, o, e); end
      end
      idle(1'b1);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         tick(o, e);
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL random_drain%0d got=%h expected=%h", i, o, e); end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequencer and final report
   // ---------------------------------------------------------------------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      m_rr     = 0;
      m_lock   = -1;
      m_ovf    = 1'b0;
      rst_ni   = 1'b0;
      idle(1'b0);

      test_reset();
      test_single();
      test_round_robin();
      test_stall_lock();
      test_overflow();
      test_mid_reset();
      test_full_pop_push();
      test_flush();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
